// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and
// buffers fetched {pc, inst} pairs in a small FIFO that feeds decode.
// A branch redirect flushes the queue and restarts fetch at the target.
module if_fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // Fetch enable depends only on queue state and redirect, never on stall,
  // so there is no combinational path from decode back to the ROM.
  assign rom_ce_o   = !rst && !w_full && !br_taken_i;
  assign rom_addr_o = r_pc;
  assign w_push     = rom_ce_o;
  assign w_pop      = !w_empty && !stall_i && !br_taken_i;

  assign id_valid_o = !w_empty;
  assign id_pc_o    = w_empty ? 32'd0 : r_pc_mem[r_rd_ptr];
  assign id_inst_o  = w_empty ? 32'd0 : r_inst_mem[r_rd_ptr];

  // PC, pointers and occupancy; a redirect overrides push, pop and stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (br_taken_i) begin
      r_pc     <= {br_target_i[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Queue storage; contents after a flush are stale but never presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= 32'd0;
        r_inst_mem[i] <= 32'd0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_pc;
      r_inst_mem[r_wr_ptr] <= rom_inst_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and randomized checks for if_fetch_queue: reset, latency,
// stall back-pressure, branch flush, PC wrap, async reset and fetch order.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_inst;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_inst;

  int n_checks = 0;
  int n_errors = 0;

  // ROM image: word n holds n + 0x100
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr >> 2) + 32'h100;
  endfunction

  assign rom_inst   = rom_word(rom_addr);
  assign w_rom_inst = rom_word(w_rom_addr);

  if_fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .br_taken_i(br_taken),
    .br_target_i(br_target), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
    .rom_inst_i(rom_inst), .id_valid_o(id_valid), .id_pc_o(id_pc),
    .id_inst_o(id_inst)
  );

  if_fetch_queue #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .br_taken_i(1'b0),
    .br_target_i(32'd0), .rom_ce_o(w_rom_ce), .rom_addr_o(w_rom_addr),
    .rom_inst_i(w_rom_inst), .id_valid_o(w_id_valid), .id_pc_o(w_id_pc),
    .id_inst_o(w_id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc;
  int          n_consumed;

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'd0;
    #2;
    chk("rst_ce",       {31'd0, rom_ce},   32'd0);
    chk("rst_addr",     rom_addr,          32'd0);
    chk("rst_valid",    {31'd0, id_valid}, 32'd0);
    chk("rst_pc",       id_pc,             32'd0);
    chk("rst_inst",     id_inst,           32'd0);
    chk("rst_wrap_addr", w_rom_addr,       32'hFFFF_FFF8);
    #10 rst = 1'b0;

    // first fetches, one per cycle, with the wrapping instance alongside
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_valid", {31'd0, id_valid}, 32'd1);
      chk("seq_pc",    id_pc,   32'(4 * k));
      chk("seq_inst",  id_inst, 32'h100 + 32'(k));
      chk("seq_ce",    {31'd0, rom_ce}, 32'd1);
      chk("wrap_pc",   w_id_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("wrap_inst", w_id_inst, rom_word(32'hFFFF_FFF8 + 32'(4 * k)));
    end

    // stall with pc 8 at the head: queue fills, fetch stops
    stall = 1'b1;
    step();
    step();
    chk("stall_ce",   {31'd0, rom_ce}, 32'd0);
    chk("stall_addr", rom_addr, 32'h10);
    chk("stall_pc",   id_pc,    32'h8);
    chk("stall_inst", id_inst,  32'h102);
    stall = 1'b0;
    step();
    chk("rel_pc0",   id_pc,   32'hC);
    chk("rel_inst0", id_inst, 32'h103);
    step();
    chk("rel_pc1",   id_pc,   32'h10);
    chk("rel_inst1", id_inst, 32'h104);

    // redirect with two entries queued while stalled
    stall = 1'b1;
    step();
    br_taken  = 1'b1;
    br_target = 32'h43;
    #1;
    chk("br_ce_low", {31'd0, rom_ce}, 32'd0);
    step();
    br_taken = 1'b0;
    #1;
    chk("br_valid", {31'd0, id_valid}, 32'd0);
    chk("br_addr",  rom_addr, 32'h40);
    chk("br_ce",    {31'd0, rom_ce}, 32'd1);
    step();
    chk("br_pc",    id_pc,   32'h40);
    chk("br_inst",  id_inst, 32'h110);

    // asynchronous reset mid-edge while full and stalled
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_ce",    {31'd0, rom_ce},   32'd0);
    chk("arst_addr",  rom_addr, 32'd0);
    chk("arst_pc",    id_pc,    32'd0);
    #2;
    rst   = 1'b0;
    stall = 1'b0;
    step();
    chk("arst_rel_pc",   id_pc,   32'd0);
    chk("arst_rel_inst", id_inst, 32'h100);

    // random stalls and periodic redirects against the architectural order
    exp_pc     = 32'd0;
    n_consumed = 0;
    for (int c = 0; c < 400; c++) begin
      stall    = ($urandom_range(0, 2) == 0);
      br_taken = ((c % 23) == 22);
      if (br_taken) br_target = $urandom_range(0, 32'hFFFF);
      #1;
      if (br_taken) begin
        exp_pc = {br_target[31:2], 2'b00};
      end else if (id_valid && !stall) begin
        chk("ord_pc",   id_pc,   exp_pc);
        chk("ord_inst", id_inst, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      step();
    end
    stall    = 1'b0;
    br_taken = 1'b0;
    chk("ord_progress", {31'd0, (n_consumed > 150)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end that drives the instruction ROM and feeds the IF/ID boundary.
- Owns the program counter and issues `rom_ce_o`/`rom_addr_o` each cycle.
- The ROM returns `rom_inst_i` combinationally in the same cycle. The block captures `{pc, inst}` into a small FIFO and presents the FIFO head to decode with a valid/stall handshake.
- Handles branch redirects by flushing the queue.

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- stall_i  input  1  decode not ready; head entry is held while high.
- br_taken_i  input  1  redirect request from execute, one-cycle pulse.
- br_target_i  input  32  redirect address; bits [1:0] are ignored and treated as 0.
- rom_ce_o  output  1  ROM chip enable (1 = enabled).
- rom_addr_o  output  32  ROM byte address; equals current pc.
- rom_inst_i  input  32  ROM read data, combinational from rom_addr_o.
- id_valid_o  output  1  head entry valid.
- id_pc_o  output  32  PC of head entry.
- id_inst_o  output  32  instruction word of head entry.

Behaviour:
- State:
  - pc[31:0]
  - DEPTH-entry storage of {pc, inst}
  - wr_ptr, rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH
  - count, log2(DEPTH)+1 bits
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC; pointers = 0; count = 0; all storage = 0.
  - While rst is high: rom_ce_o = 0, rom_addr_o = RESET_PC, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0.
- Definitions:
  - full = (count == DEPTH); empty = (count == 0).
  - rom_ce_o = !rst && !full && !br_taken_i. This is combinational from state and br_taken_i only; it never depends on stall_i.
  - rom_addr_o = pc.
  - push = rom_ce_o.
  - pop = !empty && !stall_i && !br_taken_i.
- Per rising edge, when br_taken_i = 0:
  - If push: storage[wr_ptr] <= {pc, rom_inst_i}; wr_ptr++; pc <= pc + 4. The PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - If pop: rd_ptr++.
  - count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Per rising edge, when br_taken_i = 1 (highest priority, including over stall_i and a full queue):
  - pc <= {br_target_i[31:2], 2'b00}.
  - wr_ptr, rd_ptr, count <= 0. Storage contents are don't-care.
  - No push and no pop this cycle. The current head is discarded and not consumed.
- Outputs:
  - id_valid_o = !empty.
  - id_pc_o and id_inst_o = storage[rd_ptr] when !empty, else 0.
  - Decode consumes the head on any edge where id_valid_o && !stall_i.
- Latency:
  - The first instruction appears at the output one cycle after it is fetched.
  - After reset deassertion, RESET_PC is presented on the second rising edge … i.e. valid after the first edge.
  - After a redirect edge, the target instruction is valid after the following edge, giving one bubble.
- Steady-state throughput with stall_i = 0 is one instruction per cycle. count stays at 1 and never reaches full.
- While stalled, fetching continues until count == DEPTH, then rom_ce_o drops and pc holds.
- Releasing the stall pops on the next edge. The fetch resumes in the cycle after count < DEPTH (no combinational stall-to-ce path).
- Order is strictly preserved: entries leave in fetch order with their own PC.
- Reset asserted mid-stall or mid-redirect clears everything as above. The first post-reset fetch address is RESET_PC.

Test Plan:
- Reset release, ROM word[n] = n+0x100, stall_i = 0 -> after edge 1: id_valid_o = 1, id_pc_o = 0, id_inst_o = 0x100; then pc 4, 8, 12 with inst 0x101, 0x102, 0x103, one per cycle; rom_ce_o stays 1.
- Hold stall_i = 1 from when id_pc_o = 8 -> after 2 edges count = 2, rom_ce_o = 0, rom_addr_o = 0x10, id_pc_o stays 8; release -> outputs 8, 0xC, 0x10 on consecutive cycles, with no duplicate or skipped PC.
- br_taken_i = 1, br_target_i = 0x43 while queue holds 2 entries and stall_i = 1 -> next cycle id_valid_o = 0, rom_addr_o = 0x40; following cycle id_pc_o = 0x40.
- Wrap test: RESET_PC = 32'hFFFF_FFF8 -> presented PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst for 3 ns, not aligned to any clock edge, while full and stalled -> id_valid_o = 0 and rom_ce_o = 0 immediately; after release the fetch restarts at RESET_PC.
- Random stall_i plus periodic branches versus a reference model -> the sequence of (pc, inst) consumed while id_valid_o && !stall_i matches the architectural fetch order exactly.
